encoder_164_prio_reg: RTL and testbench

ENCODER_164_PRIO_REG -- requirements
Module: encoder_164

---
 rtl/encoder_164_prio_reg_if.sv | 15 +
 rtl/encoder_164_prio_reg.sv | 83 ++++++++
 tb/tb_encoder_164_prio_reg.sv | 121 ++++++++++++
 3 files changed

// File: rtl/encoder_164_prio_reg_if.sv
// Request/code bundle for the registered 16-to-4 priority encoder.
// The master drives requests and enable; the slave (encoder) returns the code and flags.
interface encoder_164_prio_reg_if;
  localparam int unsigned IN_W   = 16;
  localparam int unsigned CODE_W = 4;

  logic [IN_W-1:0]   A;
  logic              EI;
  logic [CODE_W-1:0] L;
  logic              GS;
  logic              EO;

  modport master (output A, output EI, input L, input GS, input EO);
  modport slave  (input A, input EI, output L, output GS, output EO);
endinterface

// File: rtl/encoder_164_prio_reg.sv
// Registered 16-to-4 priority encoder built from two cascaded 8-to-3 encoders.
// A[15] has the highest priority. GS/EO give cascade status; all outputs come straight from flops.

// 8-to-3 priority encoder. Code, gs and eo are combinational.
module encoder_83 (
  input  logic       en,
  input  logic [7:0] din,
  output logic [2:0] code_c,
  output logic       gs_c,
  output logic       eo_c
);
  localparam int unsigned IN_W = 8;

  // Scan upward so the highest set bit wins. The code stays 0 when disabled or idle.
  always_comb begin
    code_c = '0;
    if (en) begin
      for (int unsigned i = 0; i < IN_W; i++) begin
        if (din[i]) code_c = 3'(i);
      end
    end
  end

  assign gs_c = en & (|din);
  assign eo_c = en & ~(|din);
endmodule

module encoder_164_prio_reg (
  input logic                  clk,
  input logic                  rst,
  encoder_164_prio_reg_if.slave bus
);
  localparam int unsigned IN_W   = 16;
  localparam int unsigned HALF_W = IN_W / 2;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned SUB_W  = CODE_W - 1;

  logic [SUB_W-1:0]  hi_code_c, lo_code_c;
  logic              hi_gs_c, hi_eo_c, lo_gs_c, lo_eo_c;
  logic [CODE_W-1:0] l_next_c;
  logic              gs_next_c, eo_next_c;

  logic [CODE_W-1:0] l_q;
  logic              gs_q, eo_q;

  // The upper byte has priority. The lower byte is enabled only when the upper byte is idle.
  encoder_83 u_hi (
    .en     (bus.EI),
    .din    (bus.A[IN_W-1:HALF_W]),
    .code_c (hi_code_c),
    .gs_c   (hi_gs_c),
    .eo_c   (hi_eo_c)
  );

  encoder_83 u_lo (
    .en     (hi_eo_c),
    .din    (bus.A[HALF_W-1:0]),
    .code_c (lo_code_c),
    .gs_c   (lo_gs_c),
    .eo_c   (lo_eo_c)
  );

  // At most one sub-encoder has a non-zero code, so OR merges the two codes.
  assign l_next_c  = {hi_gs_c, hi_code_c | lo_code_c};
  assign gs_next_c = hi_gs_c | lo_gs_c;
  assign eo_next_c = lo_eo_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q  <= '0;
      gs_q <= 1'b0;
      eo_q <= 1'b0;
    end else begin
      l_q  <= l_next_c;
      gs_q <= gs_next_c;
      eo_q <= eo_next_c;
    end
  end

  assign bus.L  = l_q;
  assign bus.GS = gs_q;
  assign bus.EO = eo_q;
endmodule

// File: tb/tb_encoder_164_prio_reg.sv
// Directed and random checks of the registered 16-to-4 priority encoder.
// The reference model is an arithmetic floor(log2(A)).
module tb_encoder_164_prio_reg;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  encoder_164_prio_reg_if bus ();

  encoder_164_prio_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: index of the highest set bit is floor(log2(a)).
  task automatic model(input logic [15:0] a, input logic ei,
                       output logic [3:0] l, output logic gs, output logic eo);
    int unsigned v;
    int unsigned idx;
    v   = a;
    idx = 0;
    while (v > 1) begin
      v   = v / 2;
      idx = idx + 1;
    end
    l  = (ei && a != 0) ? 4'(idx) : 4'd0;
    gs = ei && (a != 0);
    eo = ei && (a == 0);
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] a, input logic ei);
    logic [3:0] el;
    logic       egs, eeo;
    model(a, ei, el, egs, eeo);
    check({tag, ".L"},  32'(bus.L),  32'(el));
    check({tag, ".GS"}, 32'(bus.GS), 32'(egs));
    check({tag, ".EO"}, 32'(bus.EO), 32'(eeo));
    check({tag, ".excl"}, 32'(bus.GS & bus.EO), 32'd0);
  endtask

  // Drive one input vector, clock it through and check it one edge later.
  task automatic step(input logic [15:0] a, input logic ei, input string tag);
    bus.A  = a;
    bus.EI = ei;
    @(posedge clk);
    #1;
    check_outputs(tag, a, ei);
  endtask

  initial begin
    logic [15:0] ra;
    logic        rei;
    bus.A  = 16'h0;
    bus.EI = 1'b1;
    rst    = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_async.L",  32'(bus.L),  32'd0);
    check("rst_async.GS", 32'(bus.GS), 32'd0);
    check("rst_async.EO", 32'(bus.EO), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold.EO", 32'(bus.EO), 32'd0);
    #2 rst = 1'b0;

    step(16'h0000, 1'b1, "zero_en");
    step(16'd1,    1'b1, "bit0");
    step(16'd1028, 1'b1, "bits10_2");
    step(16'd256,  1'b0, "dis_256");
    step(16'hFFFF, 1'b0, "dis_ffff");
    step(16'hFFFF, 1'b1, "all_ones");
    for (int i = 0; i < 16; i++) step(16'd1 << i, 1'b1, $sformatf("walk%0d", i));

    // Reset between edges while L = 15 clears the outputs at once.
    step(16'h8001, 1'b1, "pre_rst");
    #2 rst = 1'b1;
    #1;
    check("mid_rst.L",  32'(bus.L),  32'd0);
    check("mid_rst.GS", 32'(bus.GS), 32'd0);
    check("mid_rst.EO", 32'(bus.EO), 32'd0);
    @(posedge clk);
    #1;
    check("rst_edge.L", 32'(bus.L), 32'd0);
    bus.A  = 16'h0400;
    bus.EI = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("post_rel.L",  32'(bus.L),  32'd0);
    check("post_rel.GS", 32'(bus.GS), 32'd0);
    @(posedge clk);
    #1;
    check_outputs("first_after_rel", 16'h0400, 1'b1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'h0;
        1:       ra = 16'd1 << $urandom_range(0, 15);
        2:       ra = 16'($urandom) >> $urandom_range(0, 15);
        default: ra = 16'($urandom);
      endcase
      rei = ($urandom_range(0, 4) != 0);
      step(ra, rei, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
